// File: rtl/vc_output_scheduler_pkg.sv
// Shared constants and types for the per-output-port VC scheduler.
// Holds the VC encodings, router direction codes and the per-VC buffer state type.
package vc_output_scheduler_pkg;

    // Virtual channel encodings: even-phase and odd-phase channels
    localparam logic VC_EVEN = 1'b0;
    localparam logic VC_ODD  = 1'b1;

    // Default datapath sizing
    localparam int DATA_WIDTH_DEF = 64;
    localparam int NUM_REQ_DEF    = 4;

    // One-hot output direction codes shared with the input interface
    localparam logic [4:0] DIR_W  = 5'b00001;
    localparam logic [4:0] DIR_E  = 5'b00010;
    localparam logic [4:0] DIR_N  = 5'b00100;
    localparam logic [4:0] DIR_S  = 5'b01000;
    localparam logic [4:0] DIR_PE = 5'b10000;

    // Per-VC buffer state; the full flag is the whole state machine
    typedef enum logic {
        VC_EMPTY = 1'b0,
        VC_FULL  = 1'b1
    } vc_state_e;

endpackage

// File: rtl/vc_output_scheduler_rr_pick.sv
// Round-robin picker: returns the first eligible index at or after ptr,
// wrapping from N-1 back to 0, as both a one-hot grant and a binary index.
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index,
    output logic          any
);

    int unsigned idx;

    // Scan N positions starting at ptr and keep the first eligible one
    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any && eligible[idx]) begin
                any        = 1'b1;
                index      = IW'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vc_output_scheduler.sv
// Per-output-port scheduler: two VCs share one link. Each cycle the VC equal to
// polarity drains to the link and the other VC may be filled from the requesters.
//
// Handshake semantics: on the link side a flit transfers on a posedge where
// send_out && receive_out; send_out never drops and data_out never changes until
// that transfer. On the request side req_valid is the valid; clear is the
// accept, a one-hot pulse meaning "your flit is taken at this edge"; requesters
// keep req_valid/data_in steady until they see clear. clear does not depend on
// receive_out, so no combinational loop forms through the input interfaces.
module vc_output_scheduler
    import vc_output_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_REQ    = NUM_REQ_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          polarity,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_vc,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
    output logic [NUM_REQ-1:0]            clear,
    output logic                          send_out,
    input  logic                          receive_out,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic [1:0]                    vc_full
);

    localparam int PW = $clog2(NUM_REQ);

    logic                  link_vc;
    logic                  fill_vc;
    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    pick_grant;
    logic [PW-1:0]         pick_index;
    logic                  pick_any;
    logic                  fill_go;
    logic                  drain;
    logic [DATA_WIDTH-1:0] req_data [NUM_REQ];

    vc_state_e             state_q [2];
    vc_state_e             state_d [2];
    logic [DATA_WIDTH-1:0] buf_q   [2];
    logic [DATA_WIDTH-1:0] buf_d   [2];
    logic [PW-1:0]         ptr_q   [2];
    logic [PW-1:0]         ptr_d   [2];

    // Phase split: one VC talks to the link while the other is being filled
    assign link_vc = polarity;
    assign fill_vc = ~polarity;

    // Unpack requester flits and mark those targeting the fill VC
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
            eligible[i] = req_valid[i] && (req_vc[i] == fill_vc);
        end
    end

    // Only the fill VC arbitrates this cycle, so one picker serves both VCs
    rr_pick #(
        .N (NUM_REQ)
    ) u_rr_pick (
        .eligible (eligible),
        .ptr      (ptr_q[fill_vc]),
        .grant    (pick_grant),
        .index    (pick_index),
        .any      (pick_any)
    );

    // A grant needs an empty fill buffer; held off entirely while in reset
    assign fill_go  = reset && pick_any && (state_q[fill_vc] == VC_EMPTY);
    assign clear    = fill_go ? pick_grant : '0;

    // Link side is decoded straight from the registers
    assign send_out = (state_q[link_vc] == VC_FULL);
    assign data_out = buf_q[link_vc];
    assign drain    = send_out && receive_out;
    assign vc_full  = {state_q[VC_ODD] == VC_FULL, state_q[VC_EVEN] == VC_FULL};

    // Next state: drain the link VC on handshake, load the fill VC on grant
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        ptr_d   = ptr_q;
        if (drain) begin
            state_d[link_vc] = VC_EMPTY;
        end
        if (fill_go) begin
            state_d[fill_vc] = VC_FULL;
            buf_d[fill_vc]   = req_data[pick_index];
            ptr_d[fill_vc]   = (pick_index == PW'(NUM_REQ - 1)) ? '0 : pick_index + 1'b1;
        end
    end

    // Per-VC state registers; reset discards any buffered flit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < 2; v++) begin
                state_q[v] <= VC_EMPTY;
                buf_q[v]   <= '0;
                ptr_q[v]   <= '0;
            end
        end else begin
            for (int v = 0; v < 2; v++) begin
                state_q[v] <= state_d[v];
                buf_q[v]   <= buf_d[v];
                ptr_q[v]   <= ptr_d[v];
            end
        end
    end

endmodule

// File: tb/tb_vc_output_scheduler.sv
// Directed bench for vc_output_scheduler: inputs change 1ns after posedge,
// outputs are checked at the following negedge.
module tb_vc_output_scheduler;

    localparam int DW = 64;
    localparam int NR = 4;

    logic             clk;
    logic             reset;
    logic             polarity;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_vc;
    logic [NR*DW-1:0] data_in;
    logic [NR-1:0]    clear;
    logic             send_out;
    logic             receive_out;
    logic [DW-1:0]    data_out;
    logic [1:0]       vc_full;

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] exp_q[$];

    vc_output_scheduler #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .polarity    (polarity),
        .req_valid   (req_valid),
        .req_vc      (req_vc),
        .data_in     (data_in),
        .clear       (clear),
        .send_out    (send_out),
        .receive_out (receive_out),
        .data_out    (data_out),
        .vc_full     (vc_full)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic drive(input logic pol, input logic [NR-1:0] rv, input logic [NR-1:0] rvc,
                         input logic rcv);
        polarity    = pol;
        req_valid   = rv;
        req_vc      = rvc;
        receive_out = rcv;
        #4;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [DW-1:0] base);
        for (int i = 0; i < NR; i++) begin
            data_in[i*DW +: DW] = base + DW'(i);
        end
    endtask

    logic [NR-1:0] oh;
    int rr_order [5] = '{0, 1, 2, 3, 0};
    int bp_order [3] = '{2, 3, 2};

    initial begin
        // 1: reset held with all requests up
        reset       = 1'b0;
        polarity    = 1'b0;
        req_valid   = 4'hF;
        req_vc      = 4'h0;
        receive_out = 1'b1;
        set_data(64'h10);
        repeat (2) @(posedge clk);
        #1;
        drive(1'b0, 4'hF, 4'h0, 1'b1);
        check("rst_clear_p0", clear, 0);
        check("rst_send", send_out, 0);
        check("rst_data", data_out, 0);
        check("rst_full", vc_full, 0);
        next_cycle();
        drive(1'b1, 4'hF, 4'hF, 1'b1);
        check("rst_clear_p1", clear, 0);
        check("rst_send_p1", send_out, 0);
        next_cycle();
        reset = 1'b1;

        // 2: single flit on VC1
        data_in = '0;
        data_in[1*DW +: DW] = 64'hA5;
        drive(1'b0, 4'b0010, 4'b0010, 1'b0);
        check("single_clear", clear, 4'b0010);
        check("single_send_idle", send_out, 0);
        next_cycle();
        drive(1'b1, 4'b0000, 4'b0000, 1'b1);
        check("single_send", send_out, 1);
        check("single_data", data_out, 64'hA5);
        check("single_full", vc_full, 2'b10);
        next_cycle();
        drive(1'b0, 4'b0000, 4'b0000, 1'b1);
        check("single_drained", vc_full, 2'b00);
        check("single_send_low", send_out, 0);
        next_cycle();

        // 3: round robin on VC0, link always ready
        set_data(64'h100);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 4'hF, 4'h0, 1'b1);
            oh = 4'b0001 << rr_order[k];
            check("rr_clear", clear, oh);
            exp_q.push_back(64'h100 + DW'(rr_order[k]));
            next_cycle();
            drive(1'b0, 4'hF, 4'h0, 1'b1);
            check("rr_send", send_out, 1);
            check("rr_data", data_out, exp_q.pop_front());
            check("rr_vc1_idle", clear, 0);
            next_cycle();
        end

        // VC1 pointer untouched by VC0 traffic: still 2 from the single-flit test
        set_data(64'h200);
        drive(1'b0, 4'hF, 4'hF, 1'b0);
        check("vc1_ptr_kept", clear, 4'b0100);
        next_cycle();

        // 4: VC1 backpressured, VC0 keeps flowing
        for (int c = 0; c < 6; c++) begin
            if (c % 2 == 0) begin
                drive(1'b1, 4'hF, 4'b0011, 1'b0);
                check("bp_hold_send", send_out, 1);
                check("bp_hold_data", data_out, 64'h202);
                oh = 4'b0001 << bp_order[c/2];
                check("bp_vc0_grant", clear, oh);
                exp_q.push_back(64'h200 + DW'(bp_order[c/2]));
            end else begin
                drive(1'b0, 4'hF, 4'b0011, 1'b1);
                check("bp_vc1_blocked", clear, 0);
                check("bp_vc0_data", data_out, exp_q.pop_front());
                check("bp_full", vc_full, 2'b11);
            end
            next_cycle();
        end
        drive(1'b1, 4'hF, 4'b0011, 1'b1);
        check("bp_release_data", data_out, 64'h202);
        check("bp_release_grant", clear, 4'b1000);
        next_cycle();
        drive(1'b0, 4'h0, 4'h0, 1'b1);
        check("bp_last_data", data_out, 64'h203);
        check("bp_last_clear", clear, 0);
        next_cycle();
        drive(1'b1, 4'h0, 4'h0, 1'b1);
        check("bp_empty", vc_full, 2'b00);
        check("bp_send_low", send_out, 0);
        next_cycle();

        // 5: wrap and skip on VC0
        set_data(64'h300);
        drive(1'b1, 4'b0100, 4'h0, 1'b1);
        check("wrap_setup", clear, 4'b0100);
        next_cycle();
        drive(1'b0, 4'h0, 4'h0, 1'b1);
        check("wrap_setup_data", data_out, 64'h302);
        next_cycle();
        drive(1'b1, 4'b0101, 4'h0, 1'b1);
        check("wrap_grant0", clear, 4'b0001);
        next_cycle();
        drive(1'b0, 4'h0, 4'h0, 1'b1);
        check("wrap_data", data_out, 64'h300);
        next_cycle();
        drive(1'b1, 4'b0101, 4'h0, 1'b1);
        check("skip_grant2", clear, 4'b0100);
        next_cycle();
        drive(1'b0, 4'h0, 4'h0, 1'b1);
        check("skip_data", data_out, 64'h302);
        next_cycle();

        // 6: reset with both VCs full
        set_data(64'hB0);
        drive(1'b0, 4'b0010, 4'b0010, 1'b0);
        check("mid_fill_vc1", clear, 4'b0010);
        next_cycle();
        drive(1'b1, 4'b0001, 4'b0000, 1'b0);
        check("mid_fill_vc0", clear, 4'b0001);
        check("mid_vc1_data", data_out, 64'hB1);
        next_cycle();
        drive(1'b0, 4'hF, 4'b1010, 1'b0);
        check("mid_both_full", vc_full, 2'b11);
        check("mid_vc0_data", data_out, 64'hB0);
        check("mid_no_clear", clear, 0);
        reset = 1'b0;
        #1;
        check("mid_rst_full", vc_full, 2'b00);
        check("mid_rst_send", send_out, 0);
        check("mid_rst_data", data_out, 0);
        check("mid_rst_clear", clear, 0);
        next_cycle();
        reset = 1'b1;
        drive(1'b1, 4'hF, 4'h0, 1'b1);
        check("post_rst_ptr0", clear, 4'b0001);
        next_cycle();
        drive(1'b0, 4'hF, 4'hF, 1'b1);
        check("post_rst_data0", data_out, 64'hB0);
        check("post_rst_ptr1", clear, 4'b0001);
        next_cycle();
        drive(1'b1, 4'h0, 4'h0, 1'b1);
        check("post_rst_send1", send_out, 1);
        check("post_rst_data1", data_out, 64'hB0);
        next_cycle();

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
